ca_mem_arbiter: RTL and testbench

- Schedules a shared single-port, double-banked cell memory between two requesters: the video prefetch path (fixed deadline, strict priority) and the cellular-automaton update engine (best effort).
- Owns the generation bank swap: video and CA reads come from the front bank, CA writes go to the back bank.
- Banks swap only at vertical-sync onset, so no displayed frame mixes generations.
- Sits between the 1280x1024 sync generator, the line buffer, the CA engine and the block RAM.

---
 rtl/ca_mem_arbiter_if.sv | 51 +++++
 rtl/ca_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_ca_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ca_mem_arbiter_if.sv
// rtl/ca_mem_arbiter_if.sv - Sync-generator, video, CA and RAM signal bundle for ca_mem_arbiter
interface ca_mem_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 17
);
    logic              in_prefetch_area;
    logic [10:0]       prefetch_x;
    logic [10:0]       counter_y;
    logic              v_sync;

    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;

    logic              ca_req;
    logic              ca_we;
    logic [ADDR_W-1:0] ca_addr;
    logic [DATA_W-1:0] ca_wdata;
    logic              ca_gnt;
    logic              ca_rvalid;
    logic [DATA_W-1:0] ca_rdata;
    logic              ca_gen_done;
    logic              ca_gen_start;
    logic [15:0]       gen_count;
    logic              frame_repeat;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W:0]   mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  in_prefetch_area, prefetch_x, counter_y, v_sync,
        input  ca_req, ca_we, ca_addr, ca_wdata, ca_gen_done,
        input  mem_rdata,
        output vid_valid, vid_data,
        output ca_gnt, ca_rvalid, ca_rdata, ca_gen_start, gen_count, frame_repeat,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Environment side: sync generator, CA engine, line buffer and RAM
    modport master (
        output in_prefetch_area, prefetch_x, counter_y, v_sync,
        output ca_req, ca_we, ca_addr, ca_wdata, ca_gen_done,
        output mem_rdata,
        input  vid_valid, vid_data,
        input  ca_gnt, ca_rvalid, ca_rdata, ca_gen_start, gen_count, frame_repeat,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/ca_mem_arbiter.sv
// rtl/ca_mem_arbiter.sv - Video/CA arbiter for a double-banked cell RAM with vsync-aligned bank swap
module ca_mem_arbiter #(
    parameter int DATA_W         = 16,
    parameter int WORDS_PER_LINE = 80,
    parameter int ADDR_W         = 17
) (
    input  logic            clk,
    input  logic            rst,
    ca_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN,
        ST_PENDING,
        ST_START
    } state_t;

    localparam logic [ADDR_W-1:0] WPL = ADDR_W'(WORDS_PER_LINE);

    state_t            state_q, state_d;
    logic              front_q, front_d;
    logic [15:0]       gen_count_q, gen_count_d;
    logic              vsync_q;
    logic              vid_pend_q;
    logic              ca_pend_q;
    logic [DATA_W-1:0] vid_hold_q;
    logic [DATA_W-1:0] ca_hold_q;

    logic              video_slot;
    logic              v_rise;
    logic              swap_busy;
    logic              ca_grant;
    logic              do_swap;
    logic              gen_start;
    logic              frame_rep;
    logic [ADDR_W-1:0] video_addr;

    // Row base address as a constant shift-add so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] mul_wpl(input logic [10:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < ADDR_W; b++) begin
            if (WPL[b]) begin
                acc = acc + (ADDR_W'(y) << b);
            end
        end
        return acc;
    endfunction

    assign video_slot = bus.in_prefetch_area && (bus.prefetch_x[3:0] == 4'd0);
    assign v_rise     = bus.v_sync && !vsync_q;
    assign swap_busy  = (state_q != ST_RUN);
    assign ca_grant   = bus.ca_req && !video_slot && !swap_busy;
    assign video_addr = mul_wpl(bus.counter_y) + ADDR_W'(bus.prefetch_x[10:4]);

    // Generation swap FSM
    always_comb begin
        state_d     = state_q;
        do_swap     = 1'b0;
        gen_start   = 1'b0;
        frame_rep   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (bus.ca_gen_done) begin
                    if (v_rise) begin
                        do_swap = 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end else if (v_rise) begin
                    frame_rep = 1'b1;
                end
            end
            ST_PENDING: begin
                if (v_rise) begin
                    do_swap = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                gen_start = 1'b1;
                state_d   = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        front_d     = front_q ^ do_swap;
        gen_count_d = gen_count_q + {15'd0, do_swap};
    end

    // RAM port: video slot wins unconditionally, CA writes target the back bank
    always_comb begin
        bus.mem_en   = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = {front_q, video_addr};
        if (video_slot) begin
            bus.mem_en = 1'b1;
        end else if (ca_grant) begin
            bus.mem_en   = 1'b1;
            bus.mem_we   = bus.ca_we;
            bus.mem_addr = {bus.ca_we ? ~front_q : front_q, bus.ca_addr};
        end
    end

    assign bus.mem_wdata    = bus.ca_wdata;
    assign bus.ca_gnt       = ca_grant;
    assign bus.ca_gen_start = gen_start;
    assign bus.frame_repeat = frame_rep;
    assign bus.gen_count    = gen_count_q;
    assign bus.vid_valid    = vid_pend_q;
    assign bus.vid_data     = vid_pend_q ? bus.mem_rdata : vid_hold_q;
    assign bus.ca_rvalid    = ca_pend_q;
    assign bus.ca_rdata     = ca_pend_q ? bus.mem_rdata : ca_hold_q;

    // Reset lands in ST_START so the CA engine is kicked off right after release
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_START;
            front_q     <= 1'b0;
            gen_count_q <= 16'd0;
            vsync_q     <= 1'b1;
            vid_pend_q  <= 1'b0;
            ca_pend_q   <= 1'b0;
            vid_hold_q  <= '0;
            ca_hold_q   <= '0;
        end else begin
            state_q     <= state_d;
            front_q     <= front_d;
            gen_count_q <= gen_count_d;
            vsync_q     <= bus.v_sync;
            vid_pend_q  <= video_slot;
            ca_pend_q   <= ca_grant && !bus.ca_we;
            if (vid_pend_q) begin
                vid_hold_q <= bus.mem_rdata;
            end
            if (ca_pend_q) begin
                ca_hold_q <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_ca_mem_arbiter.sv
// tb/tb_ca_mem_arbiter.sv - Vector, directed and randomized checks of ca_mem_arbiter against a frame-level model
module tb_ca_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    ca_mem_arbiter_if bus ();

    ca_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM contents are a fixed function of the full (bank, word) address
    function automatic logic [15:0] pat(input logic [17:0] a);
        return a[15:0] ^ {a[17], a[16], 14'h0} ^ 16'h1A2B;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= pat(bus.mem_addr);
    end

    // Model state
    bit          m_front, m_wait, m_start, m_vs_prev;
    int          m_gen;
    bit          m_vid_due, m_ca_due;
    logic [15:0] m_vid_word, m_ca_word, m_vid_hold, m_ca_hold;
    // Model expectations for the current cycle
    bit          e_slot, e_gnt, e_en, e_we, e_rise, e_blocked, e_rep;
    int          e_addr;
    logic [15:0] e_vid_data, e_ca_data;

    task automatic model_reset();
        m_front = 0; m_wait = 0; m_start = 1; m_vs_prev = 1; m_gen = 0;
        m_vid_due = 0; m_ca_due = 0;
        m_vid_word = '0; m_ca_word = '0; m_vid_hold = '0; m_ca_hold = '0;
    endtask

    task automatic model_comb();
        int px, cy, bank;
        px = int'(bus.prefetch_x);
        cy = int'(bus.counter_y);
        e_slot    = bus.in_prefetch_area && (px % 16 == 0);
        e_blocked = m_wait || m_start;
        e_gnt     = bus.ca_req && !e_slot && !e_blocked;
        e_en      = e_slot || e_gnt;
        e_we      = e_gnt && bus.ca_we;
        if (e_slot) e_addr = (m_front ? 131072 : 0) + cy * 80 + px / 16;
        else begin
            bank   = (bus.ca_we ? !m_front : m_front) ? 131072 : 0;
            e_addr = bank + int'(bus.ca_addr);
        end
        e_rise     = bus.v_sync && !m_vs_prev;
        e_rep      = e_rise && !e_blocked && !bus.ca_gen_done;
        e_vid_data = m_vid_due ? m_vid_word : m_vid_hold;
        e_ca_data  = m_ca_due ? m_ca_word : m_ca_hold;
    endtask

    task automatic model_advance();
        bit swap;
        if (rst) begin
            model_reset();
        end else begin
            swap       = e_rise && (m_wait || (!e_blocked && bus.ca_gen_done));
            m_wait     = !e_rise && (m_wait || (!e_blocked && bus.ca_gen_done));
            m_start    = swap;
            m_front    = m_front ^ swap;
            m_gen      = (m_gen + int'(swap)) % 65536;
            m_vid_hold = e_vid_data;
            m_ca_hold  = e_ca_data;
            m_vid_due  = e_slot;
            m_vid_word = pat(18'(e_addr));
            m_ca_due   = e_gnt && !bus.ca_we;
            m_ca_word  = pat(18'(e_addr));
            m_vs_prev  = bus.v_sync;
        end
    endtask

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    task automatic check_all();
        logic [95:0] got, exp;
        got = {7'd0, bus.mem_en, bus.mem_en & bus.mem_we, bus.mem_en ? bus.mem_addr : 18'd0,
               bus.ca_gnt, bus.vid_valid, bus.vid_data, bus.ca_rvalid, bus.ca_rdata,
               bus.ca_gen_start, bus.frame_repeat, bus.gen_count,
               (bus.mem_en & bus.mem_we) ? bus.mem_wdata : 16'd0};
        exp = {7'd0, e_en, e_we, e_en ? 18'(e_addr) : 18'd0,
               e_gnt, m_vid_due, e_vid_data, m_ca_due, e_ca_data,
               m_start, e_rep, 16'(m_gen),
               e_we ? bus.ca_wdata : 16'd0};
        check("cycle", got, exp);
    endtask

    // pre: evaluate model and sample outputs mid-cycle; post: clock edge then re-drive point
    task automatic pre();
        model_comb();
        #3;
        if (!rst) check_all();
    endtask

    task automatic post();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic drive(input bit pf, input int px, input int cy, input bit req, input bit we,
                         input int addr, input int wd);
        bus.in_prefetch_area = pf;
        bus.prefetch_x       = 11'(px);
        bus.counter_y        = 11'(cy);
        bus.ca_req           = req;
        bus.ca_we            = we;
        bus.ca_addr          = 17'(addr);
        bus.ca_wdata         = 16'(wd);
    endtask

    typedef struct {
        bit          pf;
        int          px, cy;
        bit          req, we;
        int          addr, wd;
        bit          x_en, x_we, x_gnt;
        int          x_addr;
    } vec_t;

    vec_t vt[10];
    int   nslots;

    initial begin
        vt[0] = '{1, 0,    2,    0, 0, 0,      0,      1, 0, 0, 160};
        vt[1] = '{1, 1264, 2,    0, 0, 0,      0,      1, 0, 0, 239};
        vt[2] = '{1, 1264, 1023, 0, 0, 0,      0,      1, 0, 0, 81919};
        vt[3] = '{1, 5,    2,    0, 0, 0,      0,      0, 0, 0, 0};
        vt[4] = '{0, 0,    2,    0, 0, 0,      0,      0, 0, 0, 0};
        vt[5] = '{1, 15,   2,    1, 0, 5,      0,      1, 0, 1, 5};
        vt[6] = '{1, 16,   2,    1, 0, 5,      0,      1, 0, 0, 161};
        vt[7] = '{0, 0,    0,    1, 1, 7,      'hBEEF, 1, 1, 1, 131079};
        vt[8] = '{1, 32,   0,    1, 1, 7,      'h1234, 1, 0, 0, 2};
        vt[9] = '{0, 3,    9,    1, 0, 131071, 0,      1, 0, 1, 131071};

        drive(0, 0, 0, 0, 0, 0, 0);
        bus.v_sync = 0;
        bus.ca_gen_done = 0;
        model_reset();
        rst = 1;
        repeat (3) begin pre(); post(); end
        rst = 0;

        // First cycle after reset
        pre();
        check("rst_gen_start", 96'(bus.ca_gen_start), 96'd1);
        check("rst_gen_count", 96'(bus.gen_count), 96'd0);
        check("rst_vid_data", 96'(bus.vid_data), 96'd0);
        check("rst_ca_rdata", 96'(bus.ca_rdata), 96'd0);
        check("rst_valids", 96'({bus.vid_valid, bus.ca_rvalid, bus.ca_gnt, bus.frame_repeat}), 96'd0);
        post();
        pre();
        check("gen_start_once", 96'(bus.ca_gen_start), 96'd0);
        post();

        // Vector table, front bank 0, RUN
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].pf, vt[i].px, vt[i].cy, vt[i].req, vt[i].we, vt[i].addr, vt[i].wd);
            pre();
            check($sformatf("vec%0d_en_we_gnt", i), 96'({bus.mem_en, bus.mem_we, bus.ca_gnt}),
                  96'({vt[i].x_en, vt[i].x_we, vt[i].x_gnt}));
            if (vt[i].x_en) check($sformatf("vec%0d_addr", i), 96'(bus.mem_addr), 96'(vt[i].x_addr));
            if (vt[i].x_we) check($sformatf("vec%0d_wdata", i), 96'(bus.mem_wdata), 96'(vt[i].wd));
            post();
        end

        // Line y=2 prefetch sweep
        nslots = 0;
        for (int x = 0; x < 1280; x++) begin
            drive(1, x, 2, 0, 0, 0, 0);
            pre();
            if (x % 16 == 0) begin
                nslots++;
                check("sweep_addr", 96'({bus.mem_en, bus.mem_addr}), 96'({1'b1, 18'(160 + x / 16)}));
            end else begin
                check("sweep_idle", 96'(bus.mem_en), 96'd0);
            end
            if (x % 16 == 1)
                check("sweep_vid", 96'({bus.vid_valid, bus.vid_data}), 96'({1'b1, pat(18'(160 + x / 16))}));
            post();
        end
        check("sweep_slots", 96'(nslots), 96'd80);

        // CA read held across a video slot
        drive(1, 15, 3, 1, 0, 5, 0);
        pre(); check("ca_x15_gnt", 96'(bus.ca_gnt), 96'd1); post();
        drive(1, 16, 3, 1, 0, 5, 0);
        pre(); check("ca_x16_gnt", 96'(bus.ca_gnt), 96'd0);
        check("ca_x16_rvalid", 96'({bus.ca_rvalid, bus.ca_rdata}), 96'({1'b1, pat(18'd5)})); post();
        drive(1, 17, 3, 1, 0, 5, 0);
        pre(); check("ca_x17_gnt", 96'({bus.ca_gnt, bus.ca_rvalid}), 96'(2'b10)); post();
        drive(1, 18, 3, 0, 0, 0, 0);
        pre(); check("ca_x18_rvalid", 96'(bus.ca_rvalid), 96'd1); post();

        // Swap: done mid-frame, grants blocked until vsync rise
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.ca_gen_done = 1;
        pre(); post();
        bus.ca_gen_done = 0;
        drive(0, 0, 0, 1, 0, 11, 0);
        for (int i = 0; i < 5; i++) begin
            pre(); check("pending_gnt", 96'(bus.ca_gnt), 96'd0); post();
        end
        bus.v_sync = 1;
        pre(); check("swap_edge", 96'({bus.ca_gnt, bus.frame_repeat, bus.ca_gen_start}), 96'd0); post();
        pre(); check("swap_start", 96'({bus.ca_gen_start, bus.gen_count, bus.ca_gnt}), 96'({1'b1, 16'd1, 1'b0})); post();
        drive(0, 0, 0, 1, 1, 7, 'h55AA);
        pre(); check("swap_wr_bank", 96'({bus.ca_gnt, bus.mem_we, bus.mem_addr}), 96'({2'b11, 18'd7})); post();
        drive(1, 0, 0, 0, 0, 0, 0);
        pre(); check("swap_vid_bank", 96'(bus.mem_addr), 96'(18'd131072)); post();
        drive(0, 0, 0, 0, 0, 0, 0);
        bus.v_sync = 0;
        repeat (3) begin pre(); post(); end
        bus.v_sync = 1;
        pre(); check("frame_repeat", 96'(bus.frame_repeat), 96'd1); post();
        pre(); check("repeat_once", 96'({bus.frame_repeat, bus.gen_count}), 96'({1'b0, 16'd1})); post();

        // Done coincident with vsync rise, twice
        for (int k = 0; k < 2; k++) begin
            bus.v_sync = 0;
            repeat (2) begin pre(); post(); end
            bus.v_sync = 1;
            bus.ca_gen_done = 1;
            pre(); check("coin_no_repeat", 96'(bus.frame_repeat), 96'd0); post();
            bus.ca_gen_done = 0;
            pre(); check("coin_start", 96'({bus.ca_gen_start, bus.gen_count}), 96'({1'b1, 16'(2 + k)})); post();
        end

        // Reset while PENDING with a CA read in flight
        bus.v_sync = 0;
        repeat (2) begin pre(); post(); end
        drive(0, 0, 0, 1, 0, 9, 0);
        bus.ca_gen_done = 1;
        pre(); check("rstp_gnt", 96'(bus.ca_gnt), 96'd1); post();
        bus.ca_gen_done = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        pre(); check("rstp_inflight", 96'(bus.ca_rvalid), 96'd1); post();
        rst = 0;
        drive(1, 0, 0, 1, 0, 9, 0);
        pre();
        check("rstp_cleared", 96'({bus.ca_rvalid, bus.ca_gen_start, bus.ca_gnt, bus.gen_count}),
              96'({1'b0, 1'b1, 1'b0, 16'd0}));
        check("rstp_front", 96'({bus.mem_en, bus.mem_addr}), 96'({1'b1, 18'd0}));
        post();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 599) == 0);
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 1279)), int'($urandom_range(0, 1023)),
                  $urandom_range(0, 1), $urandom_range(0, 1), int'($urandom_range(0, 131071)),
                  int'($urandom_range(0, 65535)));
            if ($urandom_range(0, 29) == 0) bus.v_sync = ~bus.v_sync;
            bus.ca_gen_done = ($urandom_range(0, 59) == 0);
            pre(); post();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
